div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider in the EX stage of the 5-stage pipeline.
//  Accepts a DIV/DIVU from EX and stalls the pipeline while iterating.
//  Hands quotient/remainder (LO/HI) to the EX/MEM pipeline register in a single
//  DONE cycle; its stall output feeds the hazard unit, which gates the enables
//  of the pipeline registers.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (even, >=4)
// PORTS
//  clk          in   1      single clock, all state on posedge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      EX holds a DIV/DIVU; level, held by the stalled pipeline
//  signed_div   in   1      1=DIV (two's complement), 0=DIVU; sampled with start
//  annul        in   1      flush of the EX instruction; cancels any operation
//  dividend     in   WIDTH  rs operand; sampled in IDLE when start=1
//  divisor      in   WIDTH  rt operand; sampled in IDLE when start=1
//  stall        out  1      hold IF/ID/EX while the divide is in progress
//  result_valid out  1      1 for exactly the DONE cycle
//  lo           out  WIDTH  quotient, registered
//  hi           out  WIDTH  remainder, registered
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; lo=hi=0; result_valid=0; counter=0; stall=0.
//  - States: IDLE, DIV, DONE.
//    IDLE->DIV   on start & !annul & divisor!=0. Latch |a|, |b|, sign flags; cnt=0.
//    IDLE->DONE  on start & !annul & divisor==0, with lo={WIDTH{1}}, hi=dividend.
//    DIV         one restoring step per cycle. At cnt==WIDTH-1, load lo/hi with
//                sign correction and go to DONE.
//    DONE->IDLE  always. start is ignored in DONE, so the same instruction is not
//                restarted before the pipeline advances.
//  - stall = (IDLE & start & !annul) | DIV. Combinational, so EX stalls in the
//    start cycle. stall=0 in DONE, so EX/MEM captures lo/hi that edge.
//  - Latency: start seen in IDLE at cycle 0; DIV occupies cycles 1..WIDTH;
//    DONE (result_valid=1) at cycle WIDTH+1. For the divide-by-zero case, DONE
//    is at cycle 1.
//  - Signed mode: operate on magnitudes.
//    quotient negated if dividend[MSB]^divisor[MSB].
//    remainder takes the sign of dividend.
//    min_int / -1 gives lo=min_int, hi=0 (no trap).
//  - Width rules: partial remainder is WIDTH+1 bits; magnitude of min_int is
//    represented unsigned in WIDTH bits.
//  - annul in DIV or DONE: next state IDLE; result_valid=0 next cycle; lo/hi keep
//    their previous values. annul with start in IDLE: no operation begins.
//  - lo/hi change only on the DIV->DONE or IDLE->DONE transition.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in IDLE, if |dividend| < |divisor| (nonzero divisor),
//    go IDLE->DONE directly with lo=0, hi=dividend (latency 1).
//  Undefined: every nonzero-divisor operation takes the full WIDTH+1 cycles.
//    Results are bit-identical in both builds.
// STRUCTURE
//  - Shared header defines.vh: state encodings DIV_IDLE/DIV_RUN/DIV_DONE
//    (2-bit localparams) and the DIV/DIVU funct codes used by the decoder.
//  - Sub-module div_step: combinational single restoring step. It takes the
//    partial remainder, quotient and divisor, and returns the next partial
//    remainder and quotient. Instantiated once; the FSM, counter and sign fixup
//    stay in div_unit.
// TESTING
//  1. DIVU 100/7, start held -> stall 1 for cycles 0..32; cycle 33 result_valid=1,
//     lo=14, hi=2.
//  2. DIV -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 33.
//     DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//     DIVU 5/0 -> result_valid at cycle 1, lo=0xFFFFFFFF, hi=5.
//  4. Start DIVU 100/7, annul at cycle 10 -> IDLE at cycle 11, stall=0,
//     result_valid never asserts, lo/hi unchanged.
//  5. rst asserted mid-DIV (cycle 15, async between edges) -> stall, result_valid,
//     lo, hi all 0 immediately. A new start after release completes normally.
//  6. Back-to-back: start held through DONE -> no restart. Second DIV issued the
//     cycle after DONE -> its own WIDTH+1 latency. With DIV_EARLY_OUT_EN,
//     DIVU 3/9 -> DONE at cycle 1, lo=0, hi=3.

Source files
------------

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared constants and types for the EX-stage divider.
//   - DIV_IDLE / DIV_RUN / DIV_DONE : 2-bit FSM state encodings
//   - FUNCT_DIV / FUNCT_DIVU        : R-type funct codes the decoder uses to
//                                     raise start/signed_div
//   - div_sign_t                    : sign-correction flags captured at start
// -----------------------------------------------------------------------------
package div_unit_pkg;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  typedef struct packed {
    logic neg_quo;  // quotient must be negated at the end
    logic neg_rem;  // remainder must be negated at the end
  } div_sign_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring division step.
//   The quotient register doubles as the dividend shift register: its MSB is
//   shifted into the partial remainder and the new quotient bit enters at LSB.
// Ports
//   rem_i  [WIDTH:0]   partial remainder in
//   quo_i  [WIDTH-1:0] quotient / remaining dividend bits in
//   dvsr_i [WIDTH-1:0] divisor magnitude
//   rem_o  [WIDTH:0]   partial remainder out
//   quo_o  [WIDTH-1:0] quotient out
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    // One guard bit above the shifted remainder makes the borrow visible.
    diff    = shifted - {2'b00, dvsr_i};
    if (!diff[WIDTH+1]) begin
      rem_o = diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
//   Stalls IF/ID/EX while iterating and presents LO (quotient) / HI (remainder)
//   for exactly one DONE cycle, during which stall is low so EX/MEM captures
//   them.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start              EX holds a DIV/DIVU (level, held while stalled)
//   signed_div         1 = DIV (two's complement), 0 = DIVU
//   annul              flush of the EX instruction, cancels any operation
//   dividend, divisor  operands, sampled in IDLE when start is high
//   stall              hold IF/ID/EX
//   result_valid       high for the DONE cycle only
//   lo, hi             registered quotient / remainder
// Configuration
//   DIV_EARLY_OUT_EN   when defined, |dividend| < |divisor| finishes in one
//                      cycle with lo=0, hi=dividend (same result as full run).
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // Two's complement negate when neg is set; min_int maps onto itself, which
  // read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  div_sign_t        sign_q, sign_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             go, div_by_zero, early_out;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  assign a_mag       = cond_neg(dividend, signed_div & dividend[WIDTH-1]);
  assign b_mag       = cond_neg(divisor,  signed_div & divisor[WIDTH-1]);
  assign go          = start & ~annul;
  assign div_by_zero = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  // Quotient is zero and the remainder is the dividend itself, sign included.
  assign early_out = (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    sign_d  = sign_q;
    case (state_q)
      DIV_IDLE: begin
        if (go) begin
          if (div_by_zero) begin
            state_d = DIV_DONE;
            lo_d    = '1;
            hi_d    = dividend;
          end else if (early_out) begin
            state_d = DIV_DONE;
            lo_d    = '0;
            hi_d    = dividend;
          end else begin
            state_d        = DIV_RUN;
            cnt_d          = '0;
            rem_d          = '0;
            quo_d          = a_mag;
            dvsr_d         = b_mag;
            sign_d.neg_quo = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_d.neg_rem = signed_div & dividend[WIDTH-1];
          end
        end
      end
      DIV_RUN: begin
        if (annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // Remainder is below the divisor here, so its top bit is zero.
            state_d = DIV_DONE;
            lo_d    = cond_neg(step_quo, sign_q.neg_quo);
            hi_d    = cond_neg(step_rem[WIDTH-1:0], sign_q.neg_rem);
          end
        end
      end
      // DONE ignores start: the same instruction is still in EX this cycle.
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Working datapath needs no reset: it is always loaded before use.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvsr_q <= dvsr_d;
    sign_q <= sign_d;
  end

  // Combinational so EX is already held in the cycle start is first seen.
  assign stall        = ~rst & (((state_q == DIV_IDLE) & go) | (state_q == DIV_RUN));
  assign result_valid = (state_q == DIV_DONE);
  assign lo           = lo_q;
  assign hi           = hi_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_div, annul;
  logic [W-1:0] dividend, divisor;
  logic         stall, result_valid;
  logic [W-1:0] lo, hi;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .annul        (annul),
    .dividend     (dividend),
    .divisor      (divisor),
    .stall        (stall),
    .result_valid (result_valid),
    .lo           (lo),
    .hi           (hi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           lat;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] last_lo, last_hi;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division with the architectural corner cases.
  function automatic exp_t model(input bit sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int issue);
    exp_t   e;
    int     sa, sbv;
    longint ma, mb;
    sa  = a;
    sbv = b;
    ma  = sgn ? longint'(sa)  : longint'(a);
    mb  = sgn ? longint'(sbv) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    e.lat = W + 1;
    if (b == 0) begin
      e.lo  = '1;
      e.hi  = a;
      e.lat = 1;
    end else begin
      if (!sgn) begin
        e.lo = a / b;
        e.hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = a;
        e.hi = '0;
      end else begin
        e.lo = sa / sbv;
        e.hi = sa % sbv;
      end
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) e.lat = 1;
`endif
    end
    e.due = issue + e.lat;
    return e;
  endfunction

  // Monitor: every DONE cycle is matched against the oldest expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("lo", lo, mon_e.lo);
        check("hi", hi, mon_e.hi);
        check("done_cycle", cyc, mon_e.due);
        check("stall_in_done", stall, 0);
        last_lo = mon_e.lo;
        last_hi = mon_e.hi;
      end
    end
  end

  // Issue one operation, hold start until DONE (inclusive), count stall cycles.
  task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n, st;
    @(negedge clk);
    start      = 1'b1;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    annul      = 1'b0;
    e = model(sgn, a, b, cyc);
    sb.push_back(e);
    n  = 0;
    st = 0;
    #1;
    while (!result_valid && n < 200) begin
      if (stall) st++;
      @(negedge clk);
      #1;
      n++;
    end
    if (!result_valid) check("done_timeout", 0, 1);
    else               check("stall_cycles", st, e.lat);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    #1;
    check("idle_stall", stall, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int           sel;
    bit           sgn;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    last_lo    = '0;
    last_hi    = '0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_valid", result_valid, 0);
    check("rst_lo", lo, 0);
    check("rst_hi", hi, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases, back-to-back (next op issued the cycle after DONE).
    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'd5, 32'd0);
    run_op(1'b0, 32'd3, 32'd9);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd9);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    idle_cycle();

    // start together with annul in IDLE: nothing begins.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; annul = 1'b1;
    #1;
    check("annul_idle_stall", stall, 0);
    idle_cycle();

    // annul in the middle of a divide.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; annul = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_run_stall", stall, 1);
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    #1;
    check("annul_after_stall", stall, 0);
    repeat (40) @(negedge clk);
    check("annul_lo_kept", lo, last_lo);
    check("annul_hi_kept", hi, last_hi);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b1; dividend = 32'd100; divisor = 32'd7;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_lo", lo, 0);
    check("midrst_hi", hi, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_lo = '0;
    last_hi = '0;
    run_op(1'b0, 32'd100, 32'd7);

    // Randomized operations with biased operand classes.
    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 9);
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sgn = 1'b1; end
        2: b = $urandom_range(1, 15);
        3: begin a = $urandom_range(0, 50); b = $urandom_range(51, 1000); end
        4: b = -$urandom_range(1, 15);
        default: ;
      endcase
      run_op(sgn, a, b);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    idle_cycle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
